// File: rtl/pipe_seq_pkg.sv
// Shared types and constants for the pipeline stall/flush/redirect sequencer.
package pipe_seq_pkg;

    localparam int unsigned DRAIN_CNT_W = 4;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2,
        STEP   = 2'd3
    } seq_state_t;

    typedef enum logic [1:0] {
        RDR_NONE   = 2'd0,
        RDR_BRANCH = 2'd1,
        RDR_TRAP   = 2'd2
    } redirect_t;

endpackage

// File: rtl/pipe_seq_evcnt.sv
// Enable-gated wrapping event counter, used for the optional performance counters.
module pipe_seq_evcnt #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_sequencer.sv
// Stall/flush/redirect scheduler for the five-stage pipeline.
// Define PIPE_SEQ_PERF_EN to add the stall_cnt/flush_cnt performance counters.
module pipe_sequencer
    import pipe_seq_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES = 2
`ifdef PIPE_SEQ_PERF_EN
    ,
    parameter int unsigned CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       Rst,
    input  logic       hz,
    input  logic       mem_hold,
    input  logic       branch_taken,
    input  logic       trap_req,
    input  logic       dbg_halt_req,
    input  logic       dbg_step,
    input  logic       dbg_resume,
    output logic       pc_en,
    output logic       if_id_en,
    output logic       id_ex_en,
    output logic       ex_mem_en,
    output logic       mem_wb_en,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic [1:0] redirect_sel,
    output logic       trap_take,
    output logic       dbg_halted
`ifdef PIPE_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    seq_state_t             r_state, w_next_state;
    logic [DRAIN_CNT_W-1:0] r_cnt, w_next_cnt;
    redirect_t              w_rdr;

    always_ff @(posedge clk or posedge Rst) begin
        if (Rst) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Outputs react in the same cycle as the hazard inputs; reset forces them all low.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_en     = 1'b0;
        ex_mem_en    = 1'b0;
        mem_wb_en    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        w_rdr        = RDR_NONE;
        trap_take    = 1'b0;
        dbg_halted   = 1'b0;
        if (!Rst) begin
            unique case (r_state)
                RUN, STEP: begin
                    if (mem_hold) begin
                        // full freeze; STEP also stays put until memory frees up
                    end else if (trap_req) begin
                        w_next_state = DRAIN;
                        w_next_cnt   = DRAIN_CNT_W'(DRAIN_CYCLES);
                        id_ex_en     = 1'b1;
                        id_ex_flush  = 1'b1;
                        ex_mem_en    = 1'b1;
                        mem_wb_en    = 1'b1;
                    end else if (dbg_halt_req && (r_state == RUN)) begin
                        w_next_state = HALTED;
                    end else begin
                        ex_mem_en = 1'b1;
                        mem_wb_en = 1'b1;
                        id_ex_en  = 1'b1;
                        if (hz) begin
                            id_ex_flush = 1'b1;
                        end else begin
                            pc_en    = 1'b1;
                            if_id_en = 1'b1;
                            if (branch_taken) begin
                                if_id_flush = 1'b1;
                                w_rdr       = RDR_BRANCH;
                            end
                        end
                        if (r_state == STEP) begin
                            w_next_state = HALTED;
                        end
                    end
                end
                DRAIN: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    id_ex_en    = !mem_hold;
                    ex_mem_en   = !mem_hold;
                    mem_wb_en   = !mem_hold;
                    if (!mem_hold) begin
                        w_next_cnt = r_cnt - DRAIN_CNT_W'(1);
                        if (r_cnt == DRAIN_CNT_W'(1)) begin
                            trap_take    = 1'b1;
                            w_rdr        = RDR_TRAP;
                            pc_en        = 1'b1;
                            w_next_state = RUN;
                        end
                    end
                end
                HALTED: begin
                    dbg_halted = 1'b1;
                    if (dbg_resume) begin
                        w_next_state = RUN;
                    end else if (dbg_step) begin
                        w_next_state = STEP;
                    end
                end
                default: begin
                    w_next_state = RUN;
                end
            endcase
        end
    end

    assign redirect_sel = w_rdr;

`ifdef PIPE_SEQ_PERF_EN
    logic w_stall_inc, w_flush_inc;

    assign w_stall_inc = !Rst && ((r_state == RUN) || (r_state == STEP)) && !pc_en;
    assign w_flush_inc = (w_rdr != RDR_NONE);

    pipe_seq_evcnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (Rst),
        .i_en  (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    pipe_seq_evcnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (Rst),
        .i_en  (w_flush_inc),
        .o_cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_pipe_sequencer.sv
// Directed self-checking bench for pipe_sequencer (DRAIN_CYCLES=2; perf counters when PIPE_SEQ_PERF_EN is set).
module tb_pipe_sequencer;

    logic clk, Rst;
    logic hz, mem_hold, branch_taken, trap_req, dbg_halt_req, dbg_step, dbg_resume;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, trap_take, dbg_halted;
    logic [1:0] redirect_sel;
`ifdef PIPE_SEQ_PERF_EN
    logic [3:0] stall_cnt, flush_cnt;
`endif

    int checks = 0;
    int errors = 0;

    pipe_sequencer #(
        .DRAIN_CYCLES (2)
`ifdef PIPE_SEQ_PERF_EN
        ,
        .CNT_W        (4)
`endif
    ) dut (
        .clk          (clk),
        .Rst          (Rst),
        .hz           (hz),
        .mem_hold     (mem_hold),
        .branch_taken (branch_taken),
        .trap_req     (trap_req),
        .dbg_halt_req (dbg_halt_req),
        .dbg_step     (dbg_step),
        .dbg_resume   (dbg_resume),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .id_ex_en     (id_ex_en),
        .ex_mem_en    (ex_mem_en),
        .mem_wb_en    (mem_wb_en),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .redirect_sel (redirect_sel),
        .trap_take    (trap_take),
        .dbg_halted   (dbg_halted)
`ifdef PIPE_SEQ_PERF_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Packed {pc,if_id,id_ex,ex_mem,mem_wb, if_id_fl,id_ex_fl, redirect[1:0], trap_take, halted}
    localparam logic [11:0] ALL_EN   = 12'b11111_00_00_0_0;
    localparam logic [11:0] ZERO     = 12'b00000_00_00_0_0;
    localparam logic [11:0] BUBBLE   = 12'b00111_01_00_0_0;
    localparam logic [11:0] BRANCH   = 12'b11111_10_01_0_0;
    localparam logic [11:0] DRN_RUN  = 12'b00111_11_00_0_0;
    localparam logic [11:0] DRN_HOLD = 12'b00000_11_00_0_0;
    localparam logic [11:0] DRN_TRAP = 12'b10111_11_10_1_0;
    localparam logic [11:0] HALTED   = 12'b00000_00_00_0_1;

    task automatic chk(input string tag, input logic [11:0] exp);
        logic [11:0] obs;
        obs = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
               if_id_flush, id_ex_flush, redirect_sel, trap_take, dbg_halted};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_inputs();
        hz = 0; mem_hold = 0; branch_taken = 0; trap_req = 0;
        dbg_halt_req = 0; dbg_step = 0; dbg_resume = 0;
    endtask

    initial begin
        Rst = 1;
        hz = 1; mem_hold = 1; branch_taken = 1; trap_req = 1;
        dbg_halt_req = 1; dbg_step = 1; dbg_resume = 1;
        #3 chk("reset_all_high", ZERO);
        next(); chk("reset_hold", ZERO);
        next();
        Rst = 0; clr_inputs();
        #1 chk("run_after_reset", ALL_EN);

        // hazard wins over coincident branch
        hz = 1; branch_taken = 1;
        #1 chk("hz_over_branch", BUBBLE);
        next(); hz = 0;
        #1 chk("branch_redirect", BRANCH);

        // plain trap drain
        next(); branch_taken = 0; trap_req = 1;
        #1 chk("trap_entry", BUBBLE);
        next(); trap_req = 0;
        #1 chk("drain_cnt2", DRN_RUN);
        next(); chk("drain_trap_take", DRN_TRAP);
        next(); chk("run_after_trap", ALL_EN);

        // trap with mem_hold during drain delays trap_take by 3 cycles
        trap_req = 1;
        #1 chk("trap2_entry", BUBBLE);
        next(); trap_req = 0; mem_hold = 1;
        #1 chk("drain_hold1", DRN_HOLD);
        next(); chk("drain_hold2", DRN_HOLD);
        next(); chk("drain_hold3", DRN_HOLD);
        next(); mem_hold = 0;
        #1 chk("drain_resume_cnt2", DRN_RUN);
        next(); chk("drain2_trap_take", DRN_TRAP);
        next(); chk("run_after_trap2", ALL_EN);

        // mem_hold in RUN freezes everything
        mem_hold = 1; hz = 1; branch_taken = 1;
        #1 chk("run_mem_hold", ZERO);
        next(); mem_hold = 0; hz = 0; branch_taken = 0;
        #1 chk("run_after_hold", ALL_EN);

        // debug halt, step, step+resume
        dbg_halt_req = 1;
        #1 chk("halt_entry", ZERO);
        next(); dbg_halt_req = 0;
        #1 chk("halted", HALTED);
        next(); chk("halted_idle", HALTED);
        dbg_step = 1;
        #1 chk("halted_step_in", HALTED);
        next(); dbg_step = 0;
        #1 chk("step_cycle", ALL_EN);
        next(); chk("rehalted", HALTED);
        dbg_step = 1; dbg_resume = 1;
        #1 chk("halted_step_resume", HALTED);
        next(); dbg_step = 0; dbg_resume = 0;
        #1 chk("resumed_run", ALL_EN);
        next(); chk("resumed_run2", ALL_EN);

        // step with mem_hold stays in STEP, then completes
        dbg_halt_req = 1;
        next(); dbg_halt_req = 0; dbg_step = 1;
        #1 chk("halted_again", HALTED);
        next(); dbg_step = 0; mem_hold = 1;
        #1 chk("step_held", ZERO);
        next(); mem_hold = 0;
        #1 chk("step_after_hold", ALL_EN);
        next(); chk("halt_after_step", HALTED);
        dbg_resume = 1;
        next(); dbg_resume = 0;
        #1 chk("run_again", ALL_EN);

        // halt blocked by mem_hold
        dbg_halt_req = 1; mem_hold = 1;
        #1 chk("halt_blocked", ZERO);
        next(); mem_hold = 0;
        #1 chk("halt_accepted", ZERO);
        next(); chk("halted_late", HALTED);
        dbg_resume = 1;
        next(); dbg_resume = 0;

        // trap beats halt; re-halts after trap completes
        trap_req = 1;
        #1 chk("trap_beats_halt", BUBBLE);
        next(); trap_req = 0;
        #1 chk("drain_with_halt", DRN_RUN);
        next(); chk("trap_take_with_halt", DRN_TRAP);
        next(); chk("rehalt_entry", ZERO);
        next(); chk("rehalted_after_trap", HALTED);
        dbg_halt_req = 0; dbg_resume = 1;
        next(); dbg_resume = 0;
        #1 chk("run_final", ALL_EN);

        // reset during drain drops the trap
        trap_req = 1;
        next(); trap_req = 0;
        #1 chk("drain_before_rst", DRN_RUN);
        Rst = 1;
        #1 chk("rst_mid_drain", ZERO);
        next(); Rst = 0;
        #1 chk("no_trap_after_rst", ALL_EN);
        next(); chk("no_trap_after_rst2", ALL_EN);

`ifdef PIPE_SEQ_PERF_EN
        Rst = 1;
        #1;
        checks++;
        assert (stall_cnt === 4'd0 && flush_cnt === 4'd0) else begin
            errors++;
            $error("FAIL perf_reset observed=%0d/%0d expected=0/0", stall_cnt, flush_cnt);
        end
        next(); Rst = 0; hz = 1;
        repeat (17) next();
        hz = 0; branch_taken = 1;
        next(); next();
        branch_taken = 0;
        #1;
        checks++;
        assert (stall_cnt === 4'd1) else begin
            errors++;
            $error("FAIL perf_stall observed=%0d expected=1", stall_cnt);
        end
        checks++;
        assert (flush_cnt === 4'd2) else begin
            errors++;
            $error("FAIL perf_flush observed=%0d expected=2", flush_cnt);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
